// File: rtl/fx2_bus_arbiter.sv
// fx2_bus_arbiter: registered FX2 slave-FIFO bus arbiter with turnaround gap and burst limit
module fx2_bus_arbiter #(
  parameter int unsigned BURST_MAX = 256,
  parameter int unsigned TURN_CYC  = 2,
  parameter logic [1:0]  RD_ADDR   = 2'b00,
  parameter logic [1:0]  WR_ADDR   = 2'b10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_req,
  input  logic       wr_req,
  input  logic       wr_lock,
  input  logic       rd_beat,
  input  logic       wr_beat,
  input  logic       rd_done,
  input  logic       wr_done,
  output logic       rd_grant,
  output logic       wr_grant,
  output logic       fdata_oe,
  output logic [1:0] faddr,
  output logic       turn_busy
);
  typedef enum logic [1:0] {IDLE, RD_GNT, WR_GNT, TURN} state_t;
  state_t state, state_n;
  logic tgt, tgt_n, last_wr, last_wr_n;
  logic [3:0] turn_cnt, turn_cnt_n;
  logic [15:0] beat_cnt, beat_cnt_n;
  logic [16:0] beat_inc;
  logic [1:0] faddr_n, win_addr;
  logic rd_el, win_wr, win_any, is_wr, own_req, own_beat, own_done, rel;
  assign rd_el    = rd_req & ~wr_lock;
  assign win_wr   = wr_req & (~rd_el | ~last_wr);
  assign win_any  = rd_el | wr_req;
  assign win_addr = win_wr ? WR_ADDR : RD_ADDR;
  assign is_wr    = state == WR_GNT;
  assign own_req  = is_wr ? wr_req : rd_req;
  assign own_beat = is_wr ? wr_beat : rd_beat;
  assign own_done = is_wr ? wr_done : rd_done;
  assign beat_inc = {1'b0, beat_cnt} + 17'(own_beat);
  assign rel      = own_done | ~own_req | (own_beat & (beat_inc == 17'(BURST_MAX))) | (~is_wr & wr_lock);
  always_comb begin
    state_n    = state;
    tgt_n      = tgt;
    last_wr_n  = last_wr;
    turn_cnt_n = turn_cnt;
    beat_cnt_n = beat_cnt;
    faddr_n    = faddr;
    case (state)
      IDLE: begin
        beat_cnt_n = '0;
        if (win_any && win_addr == faddr) state_n = win_wr ? WR_GNT : RD_GNT;
        else if (win_any) begin
          state_n    = TURN;
          tgt_n      = win_wr;
          faddr_n    = win_addr;
          turn_cnt_n = 4'(TURN_CYC - 1);
        end
      end
      TURN: begin
        beat_cnt_n = '0;
        state_n    = turn_cnt == '0 ? (tgt ? WR_GNT : RD_GNT) : TURN;
        turn_cnt_n = turn_cnt == '0 ? turn_cnt : turn_cnt - 4'd1;
      end
      default: begin
        beat_cnt_n = beat_inc[15:0];
        state_n    = rel ? IDLE : state;
        last_wr_n  = rel ? is_wr : last_wr;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tgt       <= 1'b0;
      last_wr   <= 1'b1;
      turn_cnt  <= '0;
      beat_cnt  <= '0;
      faddr     <= RD_ADDR;
      rd_grant  <= 1'b0;
      wr_grant  <= 1'b0;
      fdata_oe  <= 1'b0;
      turn_busy <= 1'b0;
    end else begin
      state     <= state_n;
      tgt       <= tgt_n;
      last_wr   <= last_wr_n;
      turn_cnt  <= turn_cnt_n;
      beat_cnt  <= beat_cnt_n;
      faddr     <= faddr_n;
      rd_grant  <= state_n == RD_GNT;
      wr_grant  <= state_n == WR_GNT;
      fdata_oe  <= state_n == WR_GNT;
      turn_busy <= state_n == TURN;
    end
  end
endmodule
